ball_hole_detector: RTL and testbench

//  Front end of the hole/score path. Samples the 8 asynchronous hole sensors,

---
 rtl/ball_hole_detector.sv | 179 +++++++++++++++++
 tb/tb_ball_hole_detector.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ball_hole_detector.sv
// rtl/ball_hole_detector.sv - synchronise, debounce and latch hole sensor drops into a one-hot getball word
module ball_hole_detector #(
  parameter int N_HOLES         = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [N_HOLES-1:0] hole_raw,
  input  logic               ball_ack,
  output logic [N_HOLES-1:0] getball,
  output logic               ball_valid,
  output logic [2:0]         hole_idx,
  output logic               multi_hit
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [2:0]      TOP_BIT  = 3'(N_HOLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HOLD       = 2'd1,
    WAIT_CLEAR = 2'd2
  } state_t;

  // Synchroniser stages
  logic [N_HOLES-1:0] sync1_q, sync1_d;
  logic [N_HOLES-1:0] sync2_q, sync2_d;

  // Debounce state: accepted level, its one-cycle delay, and per-bit mismatch counters
  logic [N_HOLES-1:0] stable_q, stable_d;
  logic [N_HOLES-1:0] stable_dly_q, stable_dly_d;
  logic [CW-1:0]      cnt_q [N_HOLES];
  logic [CW-1:0]      cnt_d [N_HOLES];

  // FSM state and registered outputs
  state_t             state_q, state_d;
  logic [N_HOLES-1:0] getball_q, getball_d;
  logic               ball_valid_q, ball_valid_d;
  logic [2:0]         hole_idx_q, hole_idx_d;
  logic               multi_hit_q, multi_hit_d;

  // Edge detection and rising-hole selection
  logic [N_HOLES-1:0] rise;
  logic               any_rise;
  logic               multi_rise;
  logic [2:0]         first_idx;
  logic [N_HOLES-1:0] first_onehot;

  // Two-flop synchroniser: raw level reaches sync2 two edges later
  always_comb begin
    sync1_d = hole_raw;
    sync2_d = sync1_q;
  end

  // Per-bit debounce: a new level is accepted only after DEBOUNCE_CYCLES consecutive mismatches
  always_comb begin
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    for (int i = 0; i < N_HOLES; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Rising edges of the debounced level; lowest index wins when several rise together
  always_comb begin
    rise       = stable_q & ~stable_dly_q;
    any_rise   = |rise;
    multi_rise = |(rise & (rise - N_HOLES'(1)));
    first_idx  = 3'd0;
    for (int i = N_HOLES - 1; i >= 0; i--) begin
      if (rise[i]) begin
        first_idx = 3'(i);
      end
    end
    // hole k is reported on bit (N_HOLES-1-k) so hole 0 lands on the MSB
    first_onehot = N_HOLES'(1) << (TOP_BIT - first_idx);
  end

  // FSM next state and next output values
  always_comb begin
    state_d      = state_q;
    getball_d    = getball_q;
    ball_valid_d = ball_valid_q;
    hole_idx_d   = hole_idx_q;
    multi_hit_d  = multi_hit_q;
    case (state_q)
      IDLE: begin
        // rises seen while the game is not accepting balls are simply lost
        if (enable && any_rise) begin
          getball_d    = first_onehot;
          hole_idx_d   = first_idx;
          ball_valid_d = 1'b1;
          state_d      = HOLD;
          if (multi_rise) begin
            multi_hit_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (any_rise) begin
          multi_hit_d = 1'b1;
        end
        // either an acknowledge or the game closing ends the hold; a disabled game drops the ball
        if ((ball_valid_q && ball_ack) || !enable) begin
          getball_d    = '0;
          hole_idx_d   = 3'd0;
          ball_valid_d = 1'b0;
          state_d      = WAIT_CLEAR;
        end
      end
      WAIT_CLEAR: begin
        getball_d    = '0;
        hole_idx_d   = 3'd0;
        ball_valid_d = 1'b0;
        if (any_rise) begin
          multi_hit_d = 1'b1;
        end
        // re-arm only once every hole reads empty, so a resting ball cannot score twice
        if (stable_q == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        getball_d    = '0;
        hole_idx_d   = 3'd0;
        ball_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // All state registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int i = 0; i < N_HOLES; i++) begin
        cnt_q[i] <= '0;
      end
      state_q      <= IDLE;
      getball_q    <= '0;
      ball_valid_q <= 1'b0;
      hole_idx_q   <= 3'd0;
      multi_hit_q  <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      for (int i = 0; i < N_HOLES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q      <= state_d;
      getball_q    <= getball_d;
      ball_valid_q <= ball_valid_d;
      hole_idx_q   <= hole_idx_d;
      multi_hit_q  <= multi_hit_d;
    end
  end

  assign getball    = getball_q;
  assign ball_valid = ball_valid_q;
  assign hole_idx   = hole_idx_q;
  assign multi_hit  = multi_hit_q;

endmodule

// File: tb/tb_ball_hole_detector.sv
// tb/tb_ball_hole_detector.sv - scoreboard bench for ball_hole_detector with DEBOUNCE_CYCLES=4
module tb_ball_hole_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] hole_raw;
  logic       ball_ack;
  logic [7:0] getball;
  logic       ball_valid;
  logic [2:0] hole_idx;
  logic       multi_hit;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [7:0] gb;
    logic [2:0] idx;
    logic       mh;
  } exp_t;

  exp_t exp_q[$];
  logic prev_valid = 1'b0;

  ball_hole_detector #(
    .N_HOLES        (8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .hole_raw  (hole_raw),
    .ball_ack  (ball_ack),
    .getball   (getball),
    .ball_valid(ball_valid),
    .hole_idx  (hole_idx),
    .multi_hit (multi_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic push_exp(input logic [7:0] gb, input logic [2:0] idx, input logic mh);
    exp_t e;
    e.gb  = gb;
    e.idx = idx;
    e.mh  = mh;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    check("rst_getball", getball, 8'h00);
    check("rst_valid", ball_valid, 0);
    check("rst_idx", hole_idx, 0);
    check("rst_multi", multi_hit, 0);
    rst = 1'b0;
  endtask

  task automatic ack_ball(input string name);
    ball_ack = 1'b1;
    cyc(1);
    check({name, "_ack_valid"}, ball_valid, 0);
    check({name, "_ack_getball"}, getball, 8'h00);
    check({name, "_ack_idx"}, hole_idx, 0);
    ball_ack = 1'b0;
  endtask

  // Monitor: every new ball presented by the DUT is matched against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (ball_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_ball: getball 0x%0h idx %0d with no ball expected at %0t",
                 getball, hole_idx, $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_getball", getball, e.gb);
        check("sb_idx", hole_idx, e.idx);
        check("sb_multi", multi_hit, e.mh);
      end
    end
    prev_valid = ball_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    hole_raw = 8'h00;
    ball_ack = 1'b0;
    cyc(2);
    do_reset();

    // 1: hole 2 held, ball appears exactly 7 edges after the step
    enable   = 1'b1;
    push_exp(8'b0010_0000, 3'd2, 1'b0);
    hole_raw = 8'h04;
    cyc(6);
    check("t1_valid_c6", ball_valid, 0);
    cyc(1);
    check("t1_valid_c7", ball_valid, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("t1_hold_valid", ball_valid, 1);
      check("t1_hold_getball", getball, 8'b0010_0000);
    end
    ack_ball("t1");
    hole_raw = 8'h00;
    cyc(10);

    // 2: 3-cycle glitch on hole 5 is rejected
    hole_raw = 8'h20;
    cyc(3);
    hole_raw = 8'h00;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      check("t2_no_ball", ball_valid, 0);
    end

    // 3: holes 1 and 4 together -> hole 1 wins, multi_hit set
    push_exp(8'b0100_0000, 3'd1, 1'b1);
    hole_raw = 8'h12;
    cyc(7);
    check("t3_valid", ball_valid, 1);
    check("t3_multi", multi_hit, 1);
    ack_ball("t3");
    hole_raw = 8'h00;
    cyc(10);
    do_reset();

    // 4: resting ball then a second hole -> no new ball until all clear
    enable   = 1'b1;
    push_exp(8'b1000_0000, 3'd0, 1'b0);
    hole_raw = 8'h01;
    cyc(7);
    ack_ball("t4");
    check("t4_multi_before", multi_hit, 0);
    hole_raw = 8'h81;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("t4_blocked", ball_valid, 0);
    end
    check("t4_multi_after", multi_hit, 1);
    hole_raw = 8'h00;
    cyc(10);
    push_exp(8'b0001_0000, 3'd3, 1'b1);
    hole_raw = 8'h08;
    cyc(7);
    check("t4_rearm_valid", ball_valid, 1);
    ack_ball("t4b");
    hole_raw = 8'h00;
    cyc(10);
    do_reset();

    // 5: hole 3 while disabled is ignored; disable during HOLD drops the ball
    enable   = 1'b0;
    hole_raw = 8'h08;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      check("t5_disabled", ball_valid, 0);
    end
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("t5_late_enable", ball_valid, 0);
    end
    hole_raw = 8'h00;
    cyc(10);
    push_exp(8'b0010_0000, 3'd2, 1'b0);
    hole_raw = 8'h04;
    cyc(7);
    check("t5_hold_valid", ball_valid, 1);
    enable = 1'b0;
    cyc(1);
    check("t5_drop_valid", ball_valid, 0);
    check("t5_drop_getball", getball, 8'h00);
    check("t5_drop_idx", hole_idx, 0);
    hole_raw = 8'h00;
    cyc(10);
    enable = 1'b1;
    cyc(2);

    // 6: reset during HOLD clears everything including multi_hit
    push_exp(8'b0001_0000, 3'd3, 1'b1);
    hole_raw = 8'h48;
    cyc(7);
    check("t6_hold_valid", ball_valid, 1);
    check("t6_hold_multi", multi_hit, 1);
    hole_raw = 8'h00;
    do_reset();
    cyc(10);
    check("t6_after_valid", ball_valid, 0);
    push_exp(8'b0000_0001, 3'd7, 1'b0);
    hole_raw = 8'h80;
    cyc(7);
    check("t6_idle_valid", ball_valid, 1);
    ack_ball("t6");
    hole_raw = 8'h00;
    cyc(10);

    check("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
